move_sequencer: RTL and testbench

- Initiator and controller for the 64-cell square array; it is the other end of the square command and priority bus.
- Loads the board through the write bus, then runs victim/aggressor search passes.
- Reduces the 64 returned priority codes to one winner per pass and hands pseudo-legal moves to the host one at a time, most valuable victim first.

---
 rtl/move_sequencer_if.sv | 33 +++
 rtl/move_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Host command/move bus and square-array command/priority bus of the move sequencer.
// master = sequencer side, slave = host plus square array.
interface move_sequencer_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [5:0]   cmd_sq;
   logic [3:0]   cmd_data;
   logic [2:0]   state_mode;
   logic [1:0]   mask_mode;
   logic         wtm;
   logic [3:0]   write_bus;
   logic [63:0]  ss1;
   logic [191:0] prio_bus;
   logic [63:0]  king_bus;
   logic         mv_valid;
   logic [5:0]   mv_from;
   logic [5:0]   mv_to;
   logic         mv_done;
   logic         mv_illegal;

   modport master (
      input  cmd_valid, cmd_op, cmd_sq, cmd_data, prio_bus, king_bus,
      output cmd_ready, state_mode, mask_mode, wtm, write_bus, ss1,
             mv_valid, mv_from, mv_to, mv_done, mv_illegal
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_sq, cmd_data, prio_bus, king_bus,
      input  cmd_ready, state_mode, mask_mode, wtm, write_bus, ss1,
             mv_valid, mv_from, mv_to, mv_done, mv_illegal
   );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: loads the 64-square array, runs victim/aggressor search passes and
// hands pseudo-legal moves to the host one at a time, most valuable victim first.
module move_sequencer #(
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   move_sequencer_if.master  bus
);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_NEXT  = 2'd2;
   localparam logic [1:0] OP_ABORT = 2'd3;

   localparam logic [2:0] SM_FV = 3'b000;
   localparam logic [2:0] SM_FA = 3'b010;
   localparam logic [2:0] SM_W  = 3'b100;

   typedef enum logic [3:0] {
      IDLE, WR, MEA, FV, EVV, MDV, FA, EVA, HOLD, MDA, DONE
   } state_t;

   state_t       state_reg;
   logic [1:0]   cnt_reg;
   logic [5:0]   victim_reg;
   logic [5:0]   aggressor_reg;
   logic         cmd_ready_reg;
   logic [2:0]   state_mode_reg;
   logic [1:0]   mask_mode_reg;
   logic         wtm_reg;
   logic [3:0]   write_bus_reg;
   logic [63:0]  ss1_reg;
   logic         mv_valid_reg;
   logic [5:0]   mv_from_reg;
   logic [5:0]   mv_to_reg;
   logic         mv_done_reg;
   logic         mv_illegal_reg;

   // Returns {max prio, index}; strict > keeps the lowest index on ties.
   function automatic logic [5:0] argmax8(input logic [23:0] p);
      logic [2:0] best_p;
      logic [2:0] best_i;
      best_p = p[2:0];
      best_i = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (p[3*k +: 3] > best_p) begin
            best_p = p[3*k +: 3];
            best_i = 3'(k);
         end
      end
      return {best_p, best_i};
   endfunction

   function automatic logic [63:0] onehot(input logic [5:0] sq);
      return 64'd1 << sq;
   endfunction

   logic [7:0][2:0] grp_prio;
   logic [7:0][2:0] grp_idx;
   logic [5:0]      top_sel;
   logic [2:0]      max_prio;
   logic [5:0]      max_idx;

   for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      assign {grp_prio[gi], grp_idx[gi]} = argmax8(bus.prio_bus[24*gi +: 24]);
   end

   assign top_sel  = argmax8(grp_prio);
   assign max_prio = top_sel[5:3];
   assign max_idx  = {top_sel[2:0], grp_idx[top_sel[2:0]]};

   logic take;
   logic abort_cmd;
   logic settled;
   // ABORT acts in every state, even where cmd_ready is low.
   assign take      = bus.cmd_valid && cmd_ready_reg;
   assign abort_cmd = bus.cmd_valid && (bus.cmd_op == OP_ABORT);
   assign settled   = (cnt_reg == 2'(SETTLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         victim_reg     <= '0;
         aggressor_reg  <= '0;
         cmd_ready_reg  <= 1'b0;
         state_mode_reg <= SM_FV;
         mask_mode_reg  <= 2'b00;
         wtm_reg        <= 1'b0;
         write_bus_reg  <= '0;
         ss1_reg        <= '0;
         mv_valid_reg   <= 1'b0;
         mv_from_reg    <= '0;
         mv_to_reg      <= '0;
         mv_done_reg    <= 1'b0;
         mv_illegal_reg <= 1'b0;
      end else begin
         mask_mode_reg <= 2'b00;
         if (abort_cmd) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            state_mode_reg <= SM_FV;
            ss1_reg        <= '0;
            write_bus_reg  <= '0;
            mv_valid_reg   <= 1'b0;
            mv_done_reg    <= 1'b0;
            mv_illegal_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  cmd_ready_reg <= 1'b1;
                  if (take && bus.cmd_op == OP_WRITE) begin
                     state_reg      <= WR;
                     cmd_ready_reg  <= 1'b0;
                     state_mode_reg <= SM_W;
                     ss1_reg        <= onehot(bus.cmd_sq);
                     write_bus_reg  <= bus.cmd_data;
                  end else if (take && bus.cmd_op == OP_START) begin
                     state_reg      <= MEA;
                     cmd_ready_reg  <= 1'b0;
                     wtm_reg        <= bus.cmd_data[0];
                     mv_done_reg    <= 1'b0;
                     mv_illegal_reg <= 1'b0;
                     mask_mode_reg  <= 2'b01;
                  end
               end
               WR: begin
                  state_reg      <= IDLE;
                  cmd_ready_reg  <= 1'b1;
                  state_mode_reg <= SM_FV;
                  ss1_reg        <= '0;
                  write_bus_reg  <= '0;
               end
               MEA: begin
                  state_reg <= FV;
                  cnt_reg   <= '0;
               end
               FV: begin
                  if (settled) state_reg <= EVV;
                  else         cnt_reg   <= cnt_reg + 2'd1;
               end
               EVV: begin
                  if (|bus.king_bus || max_prio == 3'd0) begin
                     state_reg      <= DONE;
                     cmd_ready_reg  <= 1'b1;
                     mv_done_reg    <= 1'b1;
                     mv_illegal_reg <= |bus.king_bus;
                  end else begin
                     state_reg     <= MDV;
                     victim_reg    <= max_idx;
                     mask_mode_reg <= 2'b10;
                     ss1_reg       <= onehot(max_idx);
                  end
               end
               MDV: begin
                  state_reg      <= FA;
                  state_mode_reg <= SM_FA;
                  cnt_reg        <= '0;
               end
               FA: begin
                  if (settled) state_reg <= EVA;
                  else         cnt_reg   <= cnt_reg + 2'd1;
               end
               EVA: begin
                  if (max_prio == 3'd0) begin
                     // Victim exhausted; its mask stays set so the next FV pass skips it.
                     state_reg      <= FV;
                     state_mode_reg <= SM_FV;
                     ss1_reg        <= '0;
                     cnt_reg        <= '0;
                  end else begin
                     state_reg     <= HOLD;
                     cmd_ready_reg <= 1'b1;
                     aggressor_reg <= max_idx;
                     mv_from_reg   <= max_idx;
                     mv_to_reg     <= victim_reg;
                     mv_valid_reg  <= 1'b1;
                  end
               end
               HOLD: begin
                  if (take && bus.cmd_op == OP_NEXT) begin
                     state_reg      <= MDA;
                     cmd_ready_reg  <= 1'b0;
                     mv_valid_reg   <= 1'b0;
                     mask_mode_reg  <= 2'b11;
                     state_mode_reg <= SM_FV;
                     ss1_reg        <= onehot(aggressor_reg);
                  end
               end
               MDA: begin
                  state_reg      <= FA;
                  state_mode_reg <= SM_FA;
                  ss1_reg        <= onehot(victim_reg);
                  cnt_reg        <= '0;
               end
               DONE: state_reg <= DONE;
               default: begin
                  state_reg      <= IDLE;
                  cmd_ready_reg  <= 1'b1;
                  state_mode_reg <= SM_FV;
                  ss1_reg        <= '0;
               end
            endcase
         end
      end
   end

   assign bus.cmd_ready  = cmd_ready_reg;
   assign bus.state_mode = state_mode_reg;
   assign bus.mask_mode  = mask_mode_reg;
   assign bus.wtm        = wtm_reg;
   assign bus.write_bus  = write_bus_reg;
   assign bus.ss1        = ss1_reg;
   assign bus.mv_valid   = mv_valid_reg;
   assign bus.mv_from    = mv_from_reg;
   assign bus.mv_to      = mv_to_reg;
   assign bus.mv_done    = mv_done_reg;
   assign bus.mv_illegal = mv_illegal_reg;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a stub square array returning fixed FV/FA priorities.
module tb_move_sequencer;
   localparam int SETTLE = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;

   logic [191:0] fv_prio = '0;
   logic [191:0] fa_prio = '0;
   logic [63:0]  fv_king = '0;

   move_sequencer_if bus();

   move_sequencer #(.SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stub array: FA mode answers with fa_prio, everything else with the FV tables.
   always_comb begin
      bus.prio_bus = (bus.state_mode == 3'b010) ? fa_prio : fv_prio;
      bus.king_bus = (bus.state_mode == 3'b000) ? fv_king : 64'd0;
   end

   function automatic logic [191:0] prio_at(input int sq, input logic [2:0] p);
      logic [191:0] v;
      v = '0;
      v[3*sq +: 3] = p;
      return v;
   endfunction

   function automatic logic [63:0] sq_bit(input int sq);
      return 64'd1 << sq;
   endfunction

   function automatic logic [89:0] out_vec();
      return {bus.state_mode, bus.mask_mode, bus.wtm, bus.write_bus, bus.ss1, bus.mv_valid,
              bus.mv_from, bus.mv_to, bus.mv_done, bus.mv_illegal, bus.cmd_ready};
   endfunction

   task automatic drive_cmd(input logic [1:0] op, input logic [5:0] sq, input logic [3:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_sq    = sq;
      bus.cmd_data  = d;
      $display("[%0t] cmd op=%0d sq=%0d data=%b", $time, op, sq, d);
   endtask

   task automatic release_cmd();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_vec() !== 90'd0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ready_after_release: got %b expected 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write();
      drive_cmd(2'd0, 6'd12, 4'b0101);
      @(negedge clk);
      release_cmd();
      checks++;
      if ({bus.state_mode, bus.ss1, bus.write_bus, bus.cmd_ready} !== {3'b100, sq_bit(12), 4'b0101, 1'b0}) begin
         fails++; $display("FAIL write_cycle: got mode=%b ss1=%h wb=%b rdy=%b expected 100/%h/0101/0",
                           bus.state_mode, bus.ss1, bus.write_bus, bus.cmd_ready, sq_bit(12));
      end
      @(negedge clk);
      checks++;
      if ({bus.state_mode, bus.ss1, bus.mask_mode, bus.cmd_ready} !== {3'b000, 64'd0, 2'b00, 1'b1}) begin
         fails++; $display("FAIL write_return_idle: got mode=%b ss1=%h mask=%b rdy=%b expected 000/0/00/1",
                           bus.state_mode, bus.ss1, bus.mask_mode, bus.cmd_ready);
      end
   endtask

   task automatic test_first_move();
      int n;
      int mdv_cycles;
      logic [63:0] mdv_ss1;
      fv_prio = prio_at(20, 3'd6) | prio_at(9, 3'd6);
      fa_prio = prio_at(3, 3'd4);
      fv_king = '0;
      drive_cmd(2'd1, 6'd0, 4'b0001);
      @(negedge clk);
      release_cmd();
      n = 0;
      checks++;
      if ({bus.mask_mode, bus.state_mode, bus.ss1, bus.wtm, bus.cmd_ready} !== {2'b01, 3'b000, 64'd0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL start_mea: got mask=%b mode=%b ss1=%h wtm=%b rdy=%b expected 01/000/0/1/0",
                           bus.mask_mode, bus.state_mode, bus.ss1, bus.wtm, bus.cmd_ready);
      end
      mdv_cycles = 0;
      mdv_ss1 = '0;
      while (!bus.mv_valid && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.mask_mode == 2'b10) begin
            mdv_cycles++;
            mdv_ss1 = bus.ss1;
         end
      end
      $display("[%0t] move from=%0d to=%0d after %0d cycles", $time, bus.mv_from, bus.mv_to, n);
      checks++;
      if (n !== 8) begin
         fails++; $display("FAIL first_move_latency: got %0d cycles expected 8", n);
      end
      checks++;
      if ({mdv_cycles, mdv_ss1} !== {32'd1, sq_bit(9)}) begin
         fails++; $display("FAIL victim_mask_pulse: got %0d cycles ss1=%h expected 1 cycle ss1=%h",
                           mdv_cycles, mdv_ss1, sq_bit(9));
      end
      checks++;
      if ({bus.mv_to, bus.mv_from, bus.mv_done} !== {6'd9, 6'd3, 1'b0}) begin
         fails++; $display("FAIL first_move_squares: got to=%0d from=%0d done=%b expected 9/3/0",
                           bus.mv_to, bus.mv_from, bus.mv_done);
      end
      @(negedge clk);
      checks++;
      if ({bus.mv_valid, bus.mv_to, bus.mv_from, bus.cmd_ready} !== {1'b1, 6'd9, 6'd3, 1'b1}) begin
         fails++; $display("FAIL hold_frozen: got v=%b to=%0d from=%0d rdy=%b expected 1/9/3/1",
                           bus.mv_valid, bus.mv_to, bus.mv_from, bus.cmd_ready);
      end
   endtask

   task automatic test_next_exhaust();
      int m;
      logic [2:0] mode_at4;
      logic [63:0] ss1_at4;
      logic valid_seen;
      fa_prio = '0;
      drive_cmd(2'd2, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      m = 0;
      checks++;
      if ({bus.mask_mode, bus.ss1, bus.state_mode, bus.mv_valid} !== {2'b11, sq_bit(3), 3'b000, 1'b0}) begin
         fails++; $display("FAIL next_mda: got mask=%b ss1=%h mode=%b v=%b expected 11/%h/000/0",
                           bus.mask_mode, bus.ss1, bus.state_mode, bus.mv_valid, sq_bit(3));
      end
      @(negedge clk);
      m++;
      checks++;
      if ({bus.state_mode, bus.ss1, bus.mask_mode} !== {3'b010, sq_bit(9), 2'b00}) begin
         fails++; $display("FAIL next_fa: got mode=%b ss1=%h mask=%b expected 010/%h/00",
                           bus.state_mode, bus.ss1, bus.mask_mode, sq_bit(9));
      end
      fv_prio = '0;
      mode_at4 = 3'b111;
      ss1_at4 = '1;
      valid_seen = 1'b0;
      while (!bus.mv_done && m < 30) begin
         @(negedge clk);
         m++;
         if (m == 4) begin
            mode_at4 = bus.state_mode;
            ss1_at4 = bus.ss1;
         end
         if (bus.mv_valid) valid_seen = 1'b1;
      end
      $display("[%0t] search done after %0d cycles illegal=%b", $time, m, bus.mv_illegal);
      checks++;
      if ({mode_at4, ss1_at4} !== {3'b000, 64'd0}) begin
         fails++; $display("FAIL back_to_fv: got mode=%b ss1=%h expected 000/0", mode_at4, ss1_at4);
      end
      checks++;
      if ({m, bus.mv_illegal, valid_seen} !== {32'd7, 1'b0, 1'b0}) begin
         fails++; $display("FAIL exhaust_done: got cycles=%0d illegal=%b valid_seen=%b expected 7/0/0",
                           m, bus.mv_illegal, valid_seen);
      end
      drive_cmd(2'd2, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      @(negedge clk);
      checks++;
      if ({bus.mv_done, bus.cmd_ready, bus.mv_valid} !== {1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL done_ignores_next: got done=%b rdy=%b v=%b expected 1/1/0",
                           bus.mv_done, bus.cmd_ready, bus.mv_valid);
      end
      drive_cmd(2'd3, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      checks++;
      if ({bus.mv_done, bus.mv_illegal, bus.cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
         fails++; $display("FAIL abort_from_done: got done=%b illegal=%b rdy=%b expected 0/0/1",
                           bus.mv_done, bus.mv_illegal, bus.cmd_ready);
      end
   endtask

   task automatic test_illegal();
      int n;
      logic valid_seen;
      fv_prio = prio_at(7, 3'd5);
      fa_prio = prio_at(2, 3'd3);
      fv_king = sq_bit(60);
      drive_cmd(2'd1, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      n = 0;
      valid_seen = 1'b0;
      while (!bus.mv_done && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.mv_valid) valid_seen = 1'b1;
      end
      $display("[%0t] king capture search done after %0d cycles illegal=%b", $time, n, bus.mv_illegal);
      checks++;
      if ({n, bus.mv_illegal, valid_seen, bus.wtm} !== {32'd4, 1'b1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL king_illegal: got cycles=%0d illegal=%b valid_seen=%b wtm=%b expected 4/1/0/0",
                           n, bus.mv_illegal, valid_seen, bus.wtm);
      end
      drive_cmd(2'd3, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      fv_king = '0;
      checks++;
      if ({bus.mv_done, bus.mv_illegal} !== 2'b00) begin
         fails++; $display("FAIL abort_clears_illegal: got done=%b illegal=%b expected 0/0",
                           bus.mv_done, bus.mv_illegal);
      end
   endtask

   task automatic test_abort_eva();
      fv_prio = prio_at(9, 3'd6);
      fa_prio = prio_at(3, 3'd4);
      drive_cmd(2'd1, 6'd0, 4'b0001);
      @(negedge clk);
      release_cmd();
      repeat (7) @(negedge clk);
      checks++;
      if ({bus.state_mode, bus.ss1, bus.mv_valid} !== {3'b010, sq_bit(9), 1'b0}) begin
         fails++; $display("FAIL pre_abort_eva: got mode=%b ss1=%h v=%b expected 010/%h/0",
                           bus.state_mode, bus.ss1, bus.mv_valid, sq_bit(9));
      end
      drive_cmd(2'd3, 6'd0, 4'b0000);
      @(negedge clk);
      release_cmd();
      checks++;
      if ({bus.mv_valid, bus.mv_done, bus.cmd_ready, bus.state_mode, bus.ss1, bus.mask_mode} !==
          {1'b0, 1'b0, 1'b1, 3'b000, 64'd0, 2'b00}) begin
         fails++; $display("FAIL abort_beats_eva: got v=%b done=%b rdy=%b mode=%b ss1=%h mask=%b expected 0/0/1/000/0/00",
                           bus.mv_valid, bus.mv_done, bus.cmd_ready, bus.state_mode, bus.ss1, bus.mask_mode);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.mv_valid, bus.state_mode, bus.cmd_ready} !== {1'b0, 3'b000, 1'b1}) begin
         fails++; $display("FAIL abort_stays_idle: got v=%b mode=%b rdy=%b expected 0/000/1",
                           bus.mv_valid, bus.state_mode, bus.cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      fv_prio = prio_at(9, 3'd6);
      fa_prio = prio_at(3, 3'd4);
      drive_cmd(2'd1, 6'd0, 4'b0001);
      @(negedge clk);
      release_cmd();
      repeat (5) @(negedge clk);
      checks++;
      if ({bus.state_mode, bus.ss1} !== {3'b010, sq_bit(9)}) begin
         fails++; $display("FAIL pre_reset_fa: got mode=%b ss1=%h expected 010/%h",
                           bus.state_mode, bus.ss1, sq_bit(9));
      end
      #2 rst_n = 1'b0;
      #1;
      $display("[%0t] async reset asserted mid-FA", $time);
      checks++;
      if (out_vec() !== 90'd0) begin
         fails++; $display("FAIL reset_mid_fa: got %h expected 0", out_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.state_mode, bus.mv_valid} !== {1'b1, 3'b000, 1'b0}) begin
         fails++; $display("FAIL ready_after_mid_reset: got rdy=%b mode=%b v=%b expected 1/000/0",
                           bus.cmd_ready, bus.state_mode, bus.mv_valid);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_sq    = 6'd0;
      bus.cmd_data  = 4'd0;
      test_reset();
      test_write();
      test_first_move();
      test_next_exhaust();
      test_illegal();
      test_abort_eva();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
